inv_share_ctrl: RTL

Round-robin controller that lets N_REQ requesters share one multi-cycle Newton-Raphson reciprocal unit (start/done handshake, Q8.24). It arbitrates requests and sequences the unit's start/done protocol, including the release phase. It guards non-positive operands and returns results to the owning requester. It sits between the UKF covariance/gain stages and the single reciprocal instance.

---
 rtl/inv_share_ctrl_pkg.sv | 17 +
 rtl/inv_share_ctrl_rr_pick.sv | 32 +++
 rtl/inv_share_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/inv_share_ctrl_pkg.sv
// Shared Q8.24 constants and controller state encoding for inv_share_ctrl.
package inv_share_ctrl_pkg;

  localparam int unsigned QWidth    = 32;
  localparam int unsigned QFracBits = 24;

  localparam logic [31:0] QOne = 32'h0100_0000;
  localparam logic [31:0] QMax = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRelease = 2'd2,
    StResp    = 2'd3
  } state_e;

endpackage

// File: rtl/inv_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module inv_share_ctrl_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic        found;
  int unsigned slot;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    slot  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      slot = (32'(ptr_i) + k) % N_REQ;
      if (!found && req_i[slot]) begin
        found       = 1'b1;
        gnt_o[slot] = 1'b1;
        idx_o       = IDX_W'(slot);
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/inv_share_ctrl.sv
// Round-robin owner of a shared start/done reciprocal unit: arbitrates, guards operands,
// sequences start/done including the release phase, and routes results back.
module inv_share_ctrl
  import inv_share_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = QWidth,
  parameter int unsigned FRAC_BITS   = QFracBits,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_dd_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_q_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic                    inv_start_o,
  output logic [DATA_W-1:0]       inv_dd_o,
  input  logic [DATA_W-1:0]       inv_q_i,
  input  logic                    inv_done_i
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  // Largest positive value: all integer and fraction bits set below the sign.
  localparam logic [DATA_W-1:0] RspMax =
      {1'b0, {(DATA_W - 1 - FRAC_BITS){1'b1}}, {FRAC_BITS{1'b1}}};

  state_e              state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   inv_dd_q, inv_dd_d;
  logic                inv_start_q, inv_start_d;
  logic [DATA_W-1:0]   rsp_q_q, rsp_q_d;
  logic                rsp_err_q, rsp_err_d;
  logic [N_REQ-1:0]    req_ready_q, req_ready_d;

  logic [N_REQ-1:0]    pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_found;
  logic [DATA_W-1:0]   pick_dd;
  logic                pick_nonpos;
  logic                timeout;

  inv_share_ctrl_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign pick_dd     = req_dd_i[pick_idx*DATA_W +: DATA_W];
  assign pick_nonpos = pick_dd[DATA_W-1] || (pick_dd == '0);
  assign timeout     = (cnt_q == CntW'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    inv_dd_d    = inv_dd_q;
    inv_start_d = inv_start_q;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = '0;
    cnt_d       = cnt_q;

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          inv_dd_d    = pick_dd;
          req_ready_d = pick_gnt;
          ptr_d       = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (pick_nonpos) begin
            rsp_q_d   = RspMax;
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end else begin
            inv_start_d = 1'b1;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        if (inv_done_i) begin
          rsp_q_d     = inv_q_i;
          rsp_err_d   = 1'b0;
          inv_start_d = 1'b0;
          state_d     = StRelease;
        end else if (timeout) begin
          rsp_q_d     = '0;
          rsp_err_d   = 1'b1;
          inv_start_d = 1'b0;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        // A done still high here belongs to the finished job; never let it leak into the next.
        if (!inv_done_i) begin
          state_d = StResp;
        end else if (timeout) begin
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (!timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      inv_dd_q    <= '0;
      inv_start_q <= 1'b0;
      rsp_q_q     <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      inv_dd_q    <= inv_dd_d;
      inv_start_q <= inv_start_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == StResp) begin
      rsp_valid_o[owner_q] = 1'b1;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_q_o     = rsp_q_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != StIdle);
  assign inv_start_o = inv_start_q;
  assign inv_dd_o    = inv_dd_q;

endmodule
